divmod31_seq: RTL and testbench

- Sequential modular divider: Y = A * B^-1 mod 31, for 5-bit operands.
- Inverse of multiplication mod 31; sits beside the existing combinational multiplier in the GF(31) arithmetic path.
- Computes B^-1 by Fermat (B^29 mod 31) with right-to-left square-and-multiply, then applies one final multiply by A.
- Valid/ready handshakes on input and output; one operation in flight.

---
 rtl/divmod31_pkg.sv | 28 ++
 rtl/multmod31.sv | 15 +
 rtl/divmod31_seq.sv | 149 ++++++++++++++
 tb/tb_divmod31_seq.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/divmod31_pkg.sv
// Shared constants and modular-reduction helper for the GF(31) sequential divider.
// Exponent 29 = 31-2 gives B^-1 by Fermat's little theorem.
package divmod31_pkg;

    localparam int             W           = 5;
    localparam logic [W-1:0]   M           = 5'd31;
    localparam logic [W-1:0]   EXP         = 5'd29;
    localparam int             FERMAT_BITS = 5;

    // FSM encoding; the S_ prefix keeps S_EXP clear of the EXP constant
    typedef logic [2:0] state_t;
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_EXP  = 3'd1;
    localparam logic [2:0] S_FIN  = 3'd2;
    localparam logic [2:0] S_CHK  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    // 2^5 == 1 mod 31, so hi*32+lo folds to hi+lo; one subtract lands in 0..30
    // for any product of two residues (max 900 -> fold sum <= 61).
    function automatic logic [W-1:0] reduce31(input logic [2*W-1:0] p);
        logic [W:0] s;
        s = {1'b0, p[2*W-1:W]} + {1'b0, p[W-1:0]};
        if (s >= {1'b0, M})
            s = s - {1'b0, M};
        return s[W-1:0];
    endfunction

endpackage

// File: rtl/multmod31.sv
// Combinational x*y mod 31 for residues 0..30.
module multmod31
    import divmod31_pkg::*;
(
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic [W-1:0] p
);

    logic [2*W-1:0] prod;

    assign prod = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    assign p    = reduce31(prod);

endmodule

// File: rtl/divmod31_seq.sv
// Sequential Y = A * B^-1 mod 31 via Fermat exponentiation (B^29), then one
// multiply by A. Optional round-trip check enabled by DIVMOD31_SELFCHECK_EN.
//
// state  | meaning
// S_IDLE | in_ready high, waiting for an operand pair
// S_EXP  | 5 square-and-multiply steps over exponent bits, LSB first
// S_FIN  | Y = a*res, zero divisor forces Y=0 and div_err
// S_CHK  | (self-check builds only) verify Y*b == a
// S_DONE | out_valid high, result held until out_ready
module divmod31_seq
    import divmod31_pkg::*;
#(
    parameter bit ZERO_FAST = 1'b0
)
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] Y,
    output logic         div_err,
    output logic         chk_err
);

    state_t       state, state_nxt;
    logic [W-1:0] a, b, res, base, e;
    logic [2:0]   cnt;
    logic [W-1:0] a_in, b_in;
    logic [W-1:0] m1_x, m1_y, m1_p, m2_p;
    logic         accept;

    assign a_in      = (A == M) ? '0 : A;
    assign b_in      = (B == M) ? '0 : B;
    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign accept    = in_valid && in_ready;

    // share the first multiplier between res*base, a*res and the Y*b check
    always_comb begin
        m1_x = res;
        m1_y = base;
        case (state)
            S_FIN: begin
                m1_x = a;
                m1_y = res;
            end
`ifdef DIVMOD31_SELFCHECK_EN
            S_CHK: begin
                m1_x = Y;
                m1_y = b;
            end
`endif
            default: ;
        endcase
    end

    multmod31 u_mul_rb (.x(m1_x), .y(m1_y), .p(m1_p));
    multmod31 u_mul_bb (.x(base), .y(base), .p(m2_p));

    // next-state decode; a zero divisor in fast mode skips straight to FIN
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept)
                        state_nxt = (ZERO_FAST && b_in == '0) ? S_FIN : S_EXP;
            S_EXP:  if (cnt == '0)
                        state_nxt = S_FIN;
`ifdef DIVMOD31_SELFCHECK_EN
            S_FIN:  state_nxt = (ZERO_FAST && b == '0) ? S_DONE : S_CHK;
            S_CHK:  state_nxt = S_DONE;
`else
            S_FIN:  state_nxt = S_DONE;
`endif
            S_DONE: if (out_ready)
                        state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // operand capture, exponentiation steps and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a       <= '0;
            b       <= '0;
            res     <= '0;
            base    <= '0;
            e       <= '0;
            cnt     <= '0;
            Y       <= '0;
            div_err <= 1'b0;
`ifdef DIVMOD31_SELFCHECK_EN
            chk_err <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    a    <= a_in;
                    b    <= b_in;
                    res  <= 5'd1;
                    base <= b_in;
                    e    <= EXP;
                    cnt  <= 3'(FERMAT_BITS - 1);
                end
                S_EXP: begin
                    if (e[0])
                        res <= m1_p;
                    base <= m2_p;
                    e    <= e >> 1;
                    if (cnt != '0)
                        cnt <= cnt - 3'd1;
                end
                S_FIN: begin
                    Y       <= (b == '0) ? '0 : m1_p;
                    div_err <= (b == '0);
                end
`ifdef DIVMOD31_SELFCHECK_EN
                S_CHK: if (!div_err && m1_p != a)
                    chk_err <= 1'b1;
`endif
                default: ;
            endcase
        end
    end

`ifdef DIVMOD31_SELFCHECK_EN
`ifndef SYNTHESIS
    // flag a failed round trip the moment it is seen
    always_ff @(posedge clk) begin
        if (rst_n && state == S_CHK && !div_err)
            assert (m1_p == a);
    end
`endif
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_divmod31_seq.sv
// Bench for divmod31_seq: directed cases, backpressure, async reset abort,
// back-to-back throughput, exhaustive operand sweep and the ZERO_FAST variant.
module tb_divmod31_seq;

`ifdef DIVMOD31_SELFCHECK_EN
    localparam int LAT = 8;
`else
    localparam int LAT = 7;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready, out_valid, out_ready, div_err, chk_err;
    logic [4:0] A, B, Y;
    logic       zf_in_valid, zf_in_ready, zf_out_valid, zf_out_ready, zf_div_err, zf_chk_err;
    logic [4:0] zf_A, zf_B, zf_Y;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    divmod31_seq #(.ZERO_FAST(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
        .Y(Y), .div_err(div_err), .chk_err(chk_err)
    );

    divmod31_seq #(.ZERO_FAST(1'b1)) dut_zf (
        .clk(clk), .rst_n(rst_n), .in_valid(zf_in_valid), .in_ready(zf_in_ready),
        .A(zf_A), .B(zf_B), .out_valid(zf_out_valid), .out_ready(zf_out_ready),
        .Y(zf_Y), .div_err(zf_div_err), .chk_err(zf_chk_err)
    );

    // reference: inverse by exhaustive search, then plain modular product
    function automatic int ref_div(input int a, input int b);
        int aa, bb;
        aa = a % 31;
        bb = b % 31;
        if (bb == 0) return 0;
        for (int x = 1; x < 31; x++)
            if ((x * bb) % 31 == 1) return (aa * x) % 31;
        return 0;
    endfunction

    // one operation on either DUT; lat = edges from accept to the first edge
    // at which the result can be handshaken
    task automatic run_op(input bit zf, input logic [4:0] av, input logic [4:0] bv,
                          input bit rnd, output int lat, output logic [4:0] yv,
                          output logic ev, output bit ok);
        int  n;
        bit  hs, rdy, ov;
        ok = 1'b0; lat = 0; yv = '0; ev = 1'b0;
        @(negedge clk);
        n = 0;
        while (!(zf ? zf_in_ready : in_ready) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) return;
        if (zf) begin
            zf_in_valid = 1'b1; zf_A = av; zf_B = bv;
            if (!rnd) zf_out_ready = 1'b1;
        end else begin
            in_valid = 1'b1; A = av; B = bv;
            if (!rnd) out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        if (zf) begin
            zf_in_valid = 1'b0; zf_A = 5'($urandom); zf_B = 5'($urandom);
        end else begin
            in_valid = 1'b0; A = 5'($urandom); B = 5'($urandom);
        end
        ov = 1'b0;
        while (lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            ov = zf ? zf_out_valid : out_valid;
            if (ov) break;
        end
        if (!ov) return;
        lat = lat + 1;
        yv = zf ? zf_Y : Y;
        ev = zf ? zf_div_err : div_err;
        hs = 1'b0;
        n  = 0;
        while (!hs && n < 50) begin
            @(negedge clk);
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (zf) zf_out_ready = rdy; else out_ready = rdy;
            @(posedge clk);
            hs = rdy;
            n++;
        end
        #1;
        ok = hs;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (Y !== 5'd0) begin failures++; $display("FAIL reset_Y: got %0d expected 0", Y); end
        checks++; if (div_err !== 1'b0) begin failures++; $display("FAIL reset_div_err: got %b expected 0", div_err); end
        checks++; if (chk_err !== 1'b0) begin failures++; $display("FAIL reset_chk_err: got %b expected 0", chk_err); end
        checks++; if (zf_in_ready !== 1'b1) begin failures++; $display("FAIL reset_zf_in_ready: got %b expected 1", zf_in_ready); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [4:0] da[5] = '{5'd1, 5'd7, 5'd31, 5'd10, 5'd0};
        logic [4:0] db[5] = '{5'd2, 5'd3, 5'd5,  5'd31, 5'd0};
        logic [4:0] dy[5] = '{5'd16, 5'd23, 5'd0, 5'd0, 5'd0};
        logic       de[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        int lat; logic [4:0] y; logic e; bit ok;
        for (int i = 0; i < 5; i++) begin
            run_op(1'b0, da[i], db[i], 1'b0, lat, y, e, ok);
            checks++; if (!ok) begin failures++; $display("FAIL directed_done[%0d]: no result/handshake", i); end
            checks++; if (lat != LAT) begin failures++; $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, LAT); end
            checks++; if (y !== dy[i]) begin failures++; $display("FAIL directed_Y[%0d]: got %0d expected %0d", i, y, dy[i]); end
            checks++; if (e !== de[i]) begin failures++; $display("FAIL directed_div_err[%0d]: got %b expected %b", i, e, de[i]); end
        end
    endtask

    task automatic test_backpressure();
        int n;
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; A = 5'd7; B = 5'd3;
        @(posedge clk);
        #1 in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #1 n++;
        end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_result: got out_valid %b expected 1", out_valid); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1; A = 5'($urandom); B = 5'($urandom);
            @(posedge clk);
            #1;
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_valid[%0d]: got %b expected 1", i, out_valid); end
            checks++; if (Y !== 5'd23) begin failures++; $display("FAIL bp_hold_Y[%0d]: got %0d expected 23", i, Y); end
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, in_ready); end
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_after_hs_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_after_hs_ready: got %b expected 1", in_ready); end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        int lat, seen; logic [4:0] y; logic e; bit ok;
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; A = 5'($urandom_range(1, 30)); B = 5'd5;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL midrst_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid: got %b expected 0", out_valid); end
        checks++; if (Y !== 5'd0) begin failures++; $display("FAIL midrst_Y: got %0d expected 0", Y); end
        checks++; if (div_err !== 1'b0) begin failures++; $display("FAIL midrst_div_err: got %b expected 0", div_err); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1 if (out_valid) seen++;
        end
        checks++; if (seen != 0) begin failures++; $display("FAIL midrst_no_output: got %0d valid cycles expected 0", seen); end
        run_op(1'b0, 5'd2, 5'd4, 1'b0, lat, y, e, ok);
        checks++; if (!ok || y !== 5'd16 || e !== 1'b0) begin failures++; $display("FAIL midrst_next_op: got ok=%0d Y=%0d err=%b expected ok=1 Y=16 err=0", ok, y, e); end
    endtask

    task automatic test_back_to_back();
        int first, second, n;
        bit r;
        first = -1; second = -1;
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; A = 5'd9; B = 5'd2;
        for (int i = 0; i < 40 && second < 0; i++) begin
            r = in_ready;
            @(posedge clk);
            if (r) begin
                if (first < 0) first = i; else second = i;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++; if (second < 0 || second - first != LAT + 1) begin failures++; $display("FAIL b2b_interval: got %0d expected %0d", second - first, LAT + 1); end
        n = 0;
        while (!in_ready && n < 30) begin
            @(negedge clk);
            n++;
        end
        checks++; if (Y !== 5'd20) begin failures++; $display("FAIL b2b_Y: got %0d expected 20", Y); end
    endtask

    task automatic test_exhaustive();
        int lat, yi, ai, bi; logic [4:0] y; logic e; bit ok;
        for (int a = 0; a < 32; a++) begin
            for (int b = 0; b < 32; b++) begin
                run_op(1'b0, 5'(a), 5'(b), 1'b1, lat, y, e, ok);
                yi = int'(y); ai = a % 31; bi = b % 31;
                checks++; if (!ok) begin failures++; $display("FAIL exh_done a=%0d b=%0d: no result/handshake", a, b); end
                if (bi != 0) begin
                    checks++; if (yi >= 31 || (yi * bi) % 31 != ai) begin failures++; $display("FAIL exh_roundtrip a=%0d b=%0d: got Y=%0d, Y*B mod 31=%0d expected %0d", a, b, yi, (yi * bi) % 31, ai); end
                    checks++; if (yi != ref_div(a, b)) begin failures++; $display("FAIL exh_Y a=%0d b=%0d: got %0d expected %0d", a, b, yi, ref_div(a, b)); end
                    checks++; if (e !== 1'b0) begin failures++; $display("FAIL exh_div_err a=%0d b=%0d: got %b expected 0", a, b, e); end
                end else begin
                    checks++; if (yi != 0 || e !== 1'b1) begin failures++; $display("FAIL exh_zero a=%0d b=%0d: got Y=%0d err=%b expected Y=0 err=1", a, b, yi, e); end
                end
            end
        end
        checks++; if (chk_err !== 1'b0) begin failures++; $display("FAIL exh_chk_err: got %b expected 0", chk_err); end
    endtask

    task automatic test_zero_fast();
        int lat; logic [4:0] y; logic e; bit ok;
        run_op(1'b1, 5'd9, 5'd0, 1'b0, lat, y, e, ok);
        checks++; if (!ok || lat != 2) begin failures++; $display("FAIL zf_zero_latency: got %0d (ok=%0d) expected 2", lat, ok); end
        checks++; if (y !== 5'd0 || e !== 1'b1) begin failures++; $display("FAIL zf_zero_result: got Y=%0d err=%b expected Y=0 err=1", y, e); end
        run_op(1'b1, 5'd9, 5'd2, 1'b0, lat, y, e, ok);
        checks++; if (!ok || lat != LAT) begin failures++; $display("FAIL zf_nonzero_latency: got %0d (ok=%0d) expected %0d", lat, ok, LAT); end
        checks++; if (y !== 5'd20 || e !== 1'b0) begin failures++; $display("FAIL zf_nonzero_result: got Y=%0d err=%b expected Y=20 err=0", y, e); end
        run_op(1'b1, 5'd13, 5'd31, 1'b0, lat, y, e, ok);
        checks++; if (!ok || lat != 2 || e !== 1'b1 || y !== 5'd0) begin failures++; $display("FAIL zf_b31: got lat=%0d Y=%0d err=%b expected lat=2 Y=0 err=1", lat, y, e); end
        checks++; if (zf_chk_err !== 1'b0) begin failures++; $display("FAIL zf_chk_err: got %b expected 0", zf_chk_err); end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; A = '0; B = '0; out_ready = 1'b1;
        zf_in_valid = 1'b0; zf_A = '0; zf_B = '0; zf_out_ready = 1'b1;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_exhaustive();
        test_zero_fast();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
